// File: rtl/vend_dispense_ctrl_if.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl_if
// Bundle of the handshake signals between the vend dispense controller and
// its surroundings (coin FSM, product motor, coin hopper).
//   vend_req    : vend request from the coin FSM
//   change_in   : change owed in 10-unit coins (0..7), sampled with vend_req
//   motor_done  : product motor completion (level or pulse)
//   hop_ack     : hopper confirms one coin ejected
//   fault_clr   : clears the FAULT state
//   busy        : controller not idle
//   motor_on    : product motor drive
//   hop_pulse   : one-cycle eject command, one coin per pulse
//   done        : one-cycle pulse at successful transaction end
//   fault       : controller is in FAULT
//   change_left : coins still to dispense
//   state       : current controller state code
// modport slave  : the controller side
// modport master : the environment side (drives requests, sees status)
// ---------------------------------------------------------------------------
interface vend_dispense_ctrl_if;
    logic       vend_req;
    logic [2:0] change_in;
    logic       motor_done;
    logic       hop_ack;
    logic       fault_clr;
    logic       busy;
    logic       motor_on;
    logic       hop_pulse;
    logic       done;
    logic       fault;
    logic [2:0] change_left;
    logic [2:0] state;

    modport slave (
        input  vend_req, change_in, motor_done, hop_ack, fault_clr,
        output busy, motor_on, hop_pulse, done, fault, change_left, state
    );

    modport master (
        output vend_req, change_in, motor_done, hop_ack, fault_clr,
        input  busy, motor_on, hop_pulse, done, fault, change_left, state
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// vend_dispense_ctrl
// Runs the product motor for a vend, then ejects the owed change one coin at
// a time through the hopper, with timeouts on both the motor and each hopper
// acknowledge. Any timeout parks the controller in FAULT (change_left kept
// for diagnosis) until fault_clr.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : vend_dispense_ctrl_if.slave handshake bundle
// Parameters:
//   MOTOR_TIMEOUT : max cycles spent in MOTOR awaiting motor_done (1..255)
//   ACK_TIMEOUT   : max cycles spent in HOP_WAIT awaiting hop_ack (1..255)
//   HOP_GAP       : idle cycles between successive hopper coins (1..15)
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module vend_dispense_ctrl #(
    parameter int MOTOR_TIMEOUT = 15,
    parameter int ACK_TIMEOUT   = 7,
    parameter int HOP_GAP       = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    vend_dispense_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOTOR     = 3'd1,
        ST_HOP_PULSE = 3'd2,
        ST_HOP_WAIT  = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5,
        ST_FAULT     = 3'd6,
        ST_ILLEGAL   = 3'd7
    } state_t;

    // The dwell counter starts at 0 on entry, so the last allowed cycle is LIMIT-1.
    localparam logic [7:0] MOTOR_LIM = 8'(MOTOR_TIMEOUT - 1);
    localparam logic [7:0] ACK_LIM   = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] GAP_LIM   = 8'(HOP_GAP - 1);

    state_t     state_r;
    state_t     state_s;
    logic [2:0] change_r;
    logic [2:0] change_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic       busy_r;
    logic       motor_r;
    logic       hop_r;
    logic       done_r;
    logic       fault_r;

    // Next-state, next-change and dwell-counter logic.
    always_comb begin
        state_s  = state_r;
        change_s = change_r;
        cnt_s    = 8'd0;
        case (state_r)
            ST_IDLE: begin
                if (bus.vend_req) begin
                    state_s  = ST_MOTOR;
                    change_s = bus.change_in;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_MOTOR: begin
                // motor_done is tested first so it beats a same-cycle timeout.
                if (bus.motor_done) begin
                    if (change_r == 3'd0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_HOP_PULSE;
                    end
                end else if (cnt_r == MOTOR_LIM) begin
                    state_s = ST_FAULT;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_HOP_PULSE: begin
                state_s = ST_HOP_WAIT;
            end
            ST_HOP_WAIT: begin
                // Ack beats a same-cycle timeout; change_left saturates at 0.
                if (bus.hop_ack) begin
                    if (change_r > 3'd1) begin
                        change_s = change_r - 3'd1;
                        state_s  = ST_GAP;
                    end else begin
                        change_s = 3'd0;
                        state_s  = ST_DONE;
                    end
                end else if (cnt_r == ACK_LIM) begin
                    state_s = ST_FAULT;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LIM) begin
                    state_s = ST_HOP_PULSE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_s  = ST_IDLE;
                    change_s = 3'd0;
                end else begin
                    state_s  = ST_FAULT;
                end
            end
            default: begin
                // Unused code 7 recovers to IDLE.
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, change, counter and decoded output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            change_r <= 3'd0;
            cnt_r    <= 8'd0;
            busy_r   <= 1'b0;
            motor_r  <= 1'b0;
            hop_r    <= 1'b0;
            done_r   <= 1'b0;
            fault_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            change_r <= change_s;
            cnt_r    <= cnt_s;
            // Outputs are decoded from the next state so they line up with state_r.
            busy_r   <= (state_s != ST_IDLE);
            motor_r  <= (state_s == ST_MOTOR);
            hop_r    <= (state_s == ST_HOP_PULSE);
            done_r   <= (state_s == ST_DONE);
            fault_r  <= (state_s == ST_FAULT);
        end
    end

    assign bus.busy        = busy_r;
    assign bus.motor_on    = motor_r;
    assign bus.hop_pulse   = hop_r;
    assign bus.done        = done_r;
    assign bus.fault       = fault_r;
    assign bus.change_left = change_r;
    assign bus.state       = state_r;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// ---------------------------------------------------------------------------
// tb_vend_dispense_ctrl
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic. A countdown-based behavioural model predicts every output each
// cycle; a separate process compares the DUT against it on every falling edge.
// ---------------------------------------------------------------------------
module tb_vend_dispense_ctrl;

    localparam int MOTOR_TIMEOUT = 15;
    localparam int ACK_TIMEOUT   = 7;
    localparam int HOP_GAP       = 2;

    logic clock;
    logic reset;
    vend_dispense_ctrl_if bus();

    vend_dispense_ctrl #(
        .MOTOR_TIMEOUT (MOTOR_TIMEOUT),
        .ACK_TIMEOUT   (ACK_TIMEOUT),
        .HOP_GAP       (HOP_GAP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int hop_cnt  = 0;
    int done_cnt = 0;

    // Behavioural model: phase uses the published state codes, timers count down.
    int m_phase = 0;
    int m_coins = 0;
    int m_tleft = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_step();
        case (m_phase)
            0: if (bus.vend_req) begin
                   m_coins = int'(bus.change_in);
                   m_tleft = MOTOR_TIMEOUT;
                   m_phase = 1;
               end
            1: if (bus.motor_done) begin
                   m_phase = (m_coins == 0) ? 5 : 2;
               end else begin
                   m_tleft--;
                   if (m_tleft == 0) m_phase = 6;
               end
            2: begin
                   m_tleft = ACK_TIMEOUT;
                   m_phase = 3;
               end
            3: if (bus.hop_ack) begin
                   m_coins = (m_coins > 0) ? m_coins - 1 : 0;
                   m_phase = (m_coins == 0) ? 5 : 4;
                   m_tleft = HOP_GAP;
               end else begin
                   m_tleft--;
                   if (m_tleft == 0) m_phase = 6;
               end
            4: begin
                   m_tleft--;
                   if (m_tleft == 0) m_phase = 2;
               end
            5: m_phase = 0;
            6: if (bus.fault_clr) begin
                   m_coins = 0;
                   m_phase = 0;
               end
            default: m_phase = 0;
        endcase
    endfunction

    // Model advances on the same edge the DUT samples; reset clears it at once.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_phase = 0;
            m_coins = 0;
            m_tleft = 0;
        end else begin
            model_step();
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clock) begin
        chk("state",       bus.state,       m_phase);
        chk("busy",        bus.busy,        m_phase != 0);
        chk("motor_on",    bus.motor_on,    m_phase == 1);
        chk("hop_pulse",   bus.hop_pulse,   m_phase == 2);
        chk("done",        bus.done,        m_phase == 5);
        chk("fault",       bus.fault,       m_phase == 6);
        chk("change_left", bus.change_left, m_coins);
    end

    task automatic step(input logic vr, input logic [2:0] chg, input logic md,
                        input logic ack, input logic fc);
        bus.vend_req   = vr;
        bus.change_in  = chg;
        bus.motor_done = md;
        bus.hop_ack    = ack;
        bus.fault_clr  = fc;
        @(posedge clock);
        @(negedge clock);
        hop_cnt  += int'(bus.hop_pulse);
        done_cnt += int'(bus.done);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_state",  bus.state,       3'd0);
        chk("rst_busy",   bus.busy,        1'b0);
        chk("rst_motor",  bus.motor_on,    1'b0);
        chk("rst_hop",    bus.hop_pulse,   1'b0);
        chk("rst_done",   bus.done,        1'b0);
        chk("rst_fault",  bus.fault,       1'b0);
        chk("rst_change", bus.change_left, 3'd0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int m;
        int np;
        int last;
        int i;
        int d0;
        int h0;

        reset = 1'b0;
        bus.vend_req   = 1'b0;
        bus.change_in  = 3'd0;
        bus.motor_done = 1'b0;
        bus.hop_ack    = 1'b0;
        bus.fault_clr  = 1'b0;
        @(negedge clock);
        chk("reset_state", bus.state, 3'd0);
        chk("reset_busy",  bus.busy,  1'b0);
        reset = 1'b1;

        // No change owed: motor then straight to done.
        d0 = done_cnt; h0 = hop_cnt;
        step(1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("t1_motor_lat", bus.motor_on, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("t1_done_state", bus.state, 3'd5);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("t1_idle", bus.state, 3'd0);
        chk("t1_busy", bus.busy, 1'b0);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_hop_cnt", hop_cnt - h0, 0);

        // Three coins, ack one cycle after every pulse.
        d0 = done_cnt;
        step(1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("t2_hop_lat", bus.hop_pulse, 1'b1);
        chk("t2_cl_0", bus.change_left, 3'd3);
        np = 1; last = 0; i = 0;
        while (bus.state != 3'd0 && i < 40) begin
            step(1'b0, 3'd0, 1'b0, bus.state == 3'd3, 1'b0);
            i++;
            if (bus.hop_pulse) begin
                chk("t2_cl_pulse", bus.change_left, 3 - np);
                chk("t2_spacing", i - last, HOP_GAP + 2);
                last = i;
                np++;
            end
            if (bus.done) chk("t2_cl_done", bus.change_left, 3'd0);
        end
        chk("t2_pulses", np, 3);
        chk("t2_done_cnt", done_cnt - d0, 1);

        // Motor never completes: fault after MOTOR_TIMEOUT cycles.
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        m = 0;
        while (bus.state == 3'd1 && m < 40) begin
            m++;
            step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("t3_motor_cycles", m, 15);
        chk("t3_fault", bus.fault, 1'b1);
        chk("t3_motor_off", bus.motor_on, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("t3_cl_held", bus.change_left, 3'd5);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("t3_clr_state", bus.state, 3'd0);
        chk("t3_clr_cl", bus.change_left, 3'd0);

        // First ack withheld: fault after ACK_TIMEOUT cycles, change kept.
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        m = 0;
        while (bus.state == 3'd3 && m < 40) begin
            m++;
            step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        end
        chk("t4_wait_cycles", m, 7);
        chk("t4_fault_state", bus.state, 3'd6);
        chk("t4_cl_held", bus.change_left, 3'd2);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

        // motor_done and hop_ack each arrive exactly on their expiry cycle.
        step(1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
        repeat (14) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("t4b_motor_edge", bus.state, 3'd2);
        chk("t4b_no_fault", bus.fault, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("t4b_ack_edge", bus.state, 3'd5);
        chk("t4b_cl", bus.change_left, 3'd0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

        // vend_req ignored while busy; reset in GAP aborts with no done.
        step(1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
        step(1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 3'd7, 1'b0, 1'b0, 1'b0);
        chk("t5_vend_ignored", bus.change_left, 3'd5);
        step(1'b1, 3'd7, 1'b0, 1'b1, 1'b0);
        chk("t5_gap", bus.state, 3'd4);
        chk("t5_cl4", bus.change_left, 3'd4);
        d0 = done_cnt;
        pulse_reset();
        step(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("t5_resume", bus.state, 3'd1);
        chk("t5_resume_cl", bus.change_left, 3'd2);
        chk("t5_no_done", done_cnt - d0, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                     $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
